// File: rtl/serial_sum_pkg.sv
// rtl/serial_sum_pkg.sv - shared types, default sizes and counter-width helper for the serial sum sequencer
package serial_sum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SS_N = 256;
    localparam int SS_W = 4;

    // A single-cycle operation still needs a one-bit counter to stay legal.
    function automatic int cnt_width(input int cc);
        return (cc <= 1) ? 1 : $clog2(cc);
    endfunction

endpackage

// File: rtl/serial_sum_slice.sv
// rtl/serial_sum_slice.sv - combinational W-bit ripple-carry adder slice built from XOR/AND full adders
module serial_sum_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic c;
    logic p;

    always_comb begin
        s = '0;
        c = cin;
        p = 1'b0;
        for (int i = 0; i < W; i++) begin
            p    = a[i] ^ b[i];
            s[i] = p ^ c;
            c    = (a[i] & b[i]) | (p & c);
        end
        cout = c;
    end

endmodule

// File: rtl/serial_sum_sequencer.sv
// rtl/serial_sum_sequencer.sv - serial adder sequencer; optional subtract mode under SERIAL_SUM_SUB_EN
module serial_sum_sequencer
    import serial_sum_pkg::*;
#(
    parameter int N = SS_N,
    parameter int W = SS_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
`ifdef SERIAL_SUM_SUB_EN
    input  logic         op_sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         carry_out,
    output logic         busy
);

    localparam int CC = N / W;
    localparam int CW = cnt_width(CC);
    localparam logic [CW-1:0] LAST_CNT = CW'(CC - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          sub_q, sub_d;
    logic          sub_in;

    logic [W-1:0]  slice_b;
    logic [W-1:0]  slice_s;
    logic          slice_cout;

`ifdef SERIAL_SUM_SUB_EN
    assign sub_in = op_sub;
`else
    assign sub_in = 1'b0;
`endif

    // Subtraction is a + ~b + 1: invert B per chunk, the +1 comes from the preset carry.
    assign slice_b = b_q[W-1:0] ^ {W{sub_q}};

    serial_sum_slice #(.W(W)) u_slice (
        .a    (a_q[W-1:0]),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        sub_d       = sub_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = op_a;
                    b_d        = op_b;
                    sub_d      = sub_in;
                    carry_d    = sub_in;
                    cnt_d      = '0;
                    sum_d      = '0;
                    cout_d     = 1'b0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                // Chunks enter at the MSB end so chunk 0 lands at the bottom after CC shifts.
                sum_d   = {slice_s, sum_q[N-1:W]};
                carry_d = slice_cout;
                a_d     = a_q >> W;
                b_d     = b_q >> W;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d       = '0;
                    cout_d      = slice_cout;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sub_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            sub_q       <= sub_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule
